// File: rtl/round_key_store.sv
`default_nettype none
// ============================================================================
// Module      : round_key_store
// Description : Holds the 60 expanded-key words of an AES-256 schedule as
//               15 x 128-bit round keys with per-word valid tracking, and
//               serves one round-key read per cycle with 1-cycle latency.
// Option      : define ROUND_KEY_ZEROIZE_EN to add the Clr/Zero_Busy
//               zeroization sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module round_key_store (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Wr_En,
    input  logic [5:0]   Word_Idx,
    input  logic [31:0]  Word_In,
    input  logic         Rd_Req,
    input  logic [3:0]   Rd_Round,
`ifdef ROUND_KEY_ZEROIZE_EN
    input  logic         Clr,
    output logic         Zero_Busy,
`endif
    output logic         Rd_Valid,
    output logic         Rd_Err,
    output logic [127:0] Rd_Key,
    output logic [5:0]   Words_Loaded,
    output logic         Keys_Done
);

    localparam int unsigned c_NUM_ROUNDS = 15;
    localparam logic [5:0]  c_LAST_WORD  = 6'd59;
    localparam logic [3:0]  c_LAST_ROUND = 4'd14;
    localparam logic [5:0]  c_NUM_WORDS  = 6'd60;

    logic [127:0] r_key [0:c_NUM_ROUNDS-1];
    logic [59:0]  r_valid;
    logic [5:0]   r_count;
    logic         r_rd_valid;
    logic         r_rd_err;
    logic [127:0] r_rd_key;

    logic         w_wiping;
    logic         w_clr_start;
    logic         w_wr;
    logic [63:0]  w_valid_ext;
    logic [5:0]   w_rd_base;
    logic [3:0]   w_rd_round_safe;
    logic         w_rd_ready;
    logic [6:0]   w_lane_lsb;

    // Lane 0 of a round sits in the most significant 32 bits of the key.
    assign w_lane_lsb      = {~Word_Idx[1:0], 5'b0_0000};
    assign w_wr            = Wr_En && (Word_Idx <= c_LAST_WORD) && !w_wiping && !w_clr_start;
    // Padding lets round 15 index four (always-clear) bits without going out of range.
    assign w_valid_ext     = {4'b0000, r_valid};
    assign w_rd_base       = {Rd_Round, 2'b00};
    assign w_rd_round_safe = (Rd_Round <= c_LAST_ROUND) ? Rd_Round : 4'd0;
    assign w_rd_ready      = (Rd_Round <= c_LAST_ROUND) && (&w_valid_ext[w_rd_base +: 4]) && !w_wiping;

`ifdef ROUND_KEY_ZEROIZE_EN
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WIPE = 1'b1
    } state_t;

    state_t     r_state;
    logic [3:0] r_wipe_idx;
    logic       r_zero_busy;

    assign w_wiping    = (r_state == ST_WIPE);
    assign w_clr_start = Clr && (r_state == ST_IDLE);
    assign Zero_Busy   = r_zero_busy;

    // Zeroization sequencer: walks rounds 0..14, busy for exactly 15 cycles.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state     <= ST_IDLE;
            r_wipe_idx  <= 4'd0;
            r_zero_busy <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (Clr) begin
                        r_state     <= ST_WIPE;
                        r_wipe_idx  <= 4'd0;
                        r_zero_busy <= 1'b1;
                    end
                end
                ST_WIPE: begin
                    if (r_wipe_idx == c_LAST_ROUND) begin
                        r_state     <= ST_IDLE;
                        r_wipe_idx  <= 4'd0;
                        r_zero_busy <= 1'b0;
                    end else begin
                        r_wipe_idx  <= r_wipe_idx + 4'd1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_zero_busy <= 1'b0;
                end
            endcase
        end
    end
`else
    assign w_wiping    = 1'b0;
    assign w_clr_start = 1'b0;
`endif

    // Key storage: word writes land in their round/lane; wipe clears a round per cycle.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < c_NUM_ROUNDS; i++) begin
                r_key[i] <= '0;
            end
        end else begin
            if (w_wr) begin
                r_key[Word_Idx[5:2]][w_lane_lsb +: 32] <= Word_In;
            end
`ifdef ROUND_KEY_ZEROIZE_EN
            if (w_wiping) begin
                r_key[r_wipe_idx] <= '0;
            end
`endif
        end
    end

    // Valid bits and distinct-word count; word 0 starts a fresh key schedule.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_valid <= '0;
            r_count <= 6'd0;
        end else if (w_clr_start) begin
            r_valid <= '0;
            r_count <= 6'd0;
        end else if (w_wr) begin
            if (Word_Idx == 6'd0) begin
                r_valid <= 60'd1;
                r_count <= 6'd1;
            end else if (!r_valid[Word_Idx]) begin
                r_valid[Word_Idx] <= 1'b1;
                r_count           <= r_count + 6'd1;
            end
        end
    end

    // Read response: one registered Valid or Err pulse per request; key held when idle.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
            r_rd_key   <= '0;
        end else begin
            r_rd_valid <= Rd_Req && w_rd_ready;
            r_rd_err   <= Rd_Req && !w_rd_ready;
            if (Rd_Req) begin
                r_rd_key <= w_rd_ready ? r_key[w_rd_round_safe] : 128'd0;
            end
        end
    end

    assign Rd_Valid     = r_rd_valid;
    assign Rd_Err       = r_rd_err;
    assign Rd_Key       = r_rd_key;
    assign Words_Loaded = r_count;
    assign Keys_Done    = (r_count == c_NUM_WORDS);

endmodule
`default_nettype wire

// File: tb/tb_round_key_store.sv
`default_nettype none
// ============================================================================
// Module      : tb_round_key_store
// Description : Directed bench for round_key_store with a response
//               scoreboard and a small behavioural model of the key store.
//               Zeroization steps are included when ROUND_KEY_ZEROIZE_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_round_key_store;

    logic         Clk = 1'b0;
    logic         Rst = 1'b0;
    logic         Wr_En = 1'b0;
    logic [5:0]   Word_Idx = 6'd0;
    logic [31:0]  Word_In = 32'd0;
    logic         Rd_Req = 1'b0;
    logic [3:0]   Rd_Round = 4'd0;
    logic         Rd_Valid;
    logic         Rd_Err;
    logic [127:0] Rd_Key;
    logic [5:0]   Words_Loaded;
    logic         Keys_Done;
`ifdef ROUND_KEY_ZEROIZE_EN
    logic         Clr = 1'b0;
    logic         Zero_Busy;
    int           wipe_left = 0;
`endif

    round_key_store dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Wr_En        (Wr_En),
        .Word_Idx     (Word_Idx),
        .Word_In      (Word_In),
        .Rd_Req       (Rd_Req),
        .Rd_Round     (Rd_Round),
`ifdef ROUND_KEY_ZEROIZE_EN
        .Clr          (Clr),
        .Zero_Busy    (Zero_Busy),
`endif
        .Rd_Valid     (Rd_Valid),
        .Rd_Err       (Rd_Err),
        .Rd_Key       (Rd_Key),
        .Words_Loaded (Words_Loaded),
        .Keys_Done    (Keys_Done)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic         v;
        logic         e;
        logic [127:0] k;
    } resp_t;

    resp_t        sb_q[$];
    logic [31:0]  m_word [0:59];
    logic [59:0]  m_valid;
    int           m_count;
    logic [127:0] m_last_key;
    int           checks = 0;
    int           errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic resp_t model_read(input logic [3:0] r, input logic busy);
        resp_t x;
        x.v = 1'b0;
        x.e = 1'b1;
        x.k = '0;
        if (!busy && r <= 4'd14) begin
            if (m_valid[4*r] && m_valid[4*r+1] && m_valid[4*r+2] && m_valid[4*r+3]) begin
                x.v = 1'b1;
                x.e = 1'b0;
                for (int j = 0; j < 4; j++) begin
                    x.k[127-32*j -: 32] = m_word[4*r+j];
                end
            end
        end
        return x;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 60; i++) m_word[i] = 32'd0;
        m_valid    = '0;
        m_count    = 0;
        m_last_key = '0;
        sb_q.delete();
    endtask

    // One clock cycle: drive inputs, predict, clock, compare.
    task automatic cycle(input logic wr, input int idx, input logic [31:0] d,
                         input logic rd, input int rnd, input logic clr);
        resp_t exp;
        logic  busy;
        logic  blocked;
        busy = 1'b0;
`ifdef ROUND_KEY_ZEROIZE_EN
        busy = (wipe_left > 0);
        Clr  = clr;
`endif
        blocked  = busy | clr;
        Wr_En    = wr;
        Word_Idx = idx[5:0];
        Word_In  = d;
        Rd_Req   = rd;
        Rd_Round = rnd[3:0];
        if (rd) sb_q.push_back(model_read(rnd[3:0], busy));
`ifdef ROUND_KEY_ZEROIZE_EN
        if (clr && !busy) begin
            m_valid   = '0;
            m_count   = 0;
            wipe_left = 15;
        end else if (busy) begin
            wipe_left--;
        end
`else
        blocked = 1'b0;
`endif
        if (wr && idx <= 59 && !blocked) begin
            m_word[idx] = d;
            if (idx == 0) begin
                m_valid = 60'd1;
                m_count = 1;
            end else if (!m_valid[idx]) begin
                m_valid[idx] = 1'b1;
                m_count++;
            end
        end
        @(posedge Clk);
        #1;
        if (sb_q.size() > 0) exp = sb_q.pop_front();
        else exp = {1'b0, 1'b0, m_last_key};
        m_last_key = exp.k;
        check("rd_valid", {127'd0, Rd_Valid}, {127'd0, exp.v});
        check("rd_err", {127'd0, Rd_Err}, {127'd0, exp.e});
        check("rd_key", Rd_Key, exp.k);
        check("words_loaded", {122'd0, Words_Loaded}, 128'(m_count));
        check("keys_done", {127'd0, Keys_Done}, {127'd0, (m_count == 60)});
`ifdef ROUND_KEY_ZEROIZE_EN
        check("zero_busy", {127'd0, Zero_Busy}, {127'd0, (wipe_left > 0)});
`endif
    endtask

    task automatic idle();
        cycle(1'b0, 0, 32'd0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        // Reset values while Rst is held low from time zero
        #2;
        check("reset_valid", {127'd0, Rd_Valid}, 128'd0);
        check("reset_err", {127'd0, Rd_Err}, 128'd0);
        check("reset_key", Rd_Key, 128'd0);
        check("reset_count", {122'd0, Words_Loaded}, 128'd0);
        check("reset_done", {127'd0, Keys_Done}, 128'd0);
        @(posedge Clk);
        #1;
        Rst = 1'b1;

        // Partial load: round 0 ready, round 1 not, round 15 never
        for (int i = 0; i < 4; i++) cycle(1'b1, i, i * 32'h0101_0101, 1'b0, 0, 1'b0);
        cycle(1'b0, 0, 32'd0, 1'b1, 0, 1'b0);
        cycle(1'b0, 0, 32'd0, 1'b1, 1, 1'b0);
        cycle(1'b0, 0, 32'd0, 1'b1, 15, 1'b0);
        idle();

        // Complete the load, with one read of a not-yet-ready round mid-load
        for (int i = 4; i < 60; i++) cycle(1'b1, i, i * 32'h0101_0101, (i == 6), 1, 1'b0);
        // Back-to-back reads of every round
        for (int r = 0; r < 15; r++) cycle(1'b0, 0, 32'd0, 1'b1, r, 1'b0);
        check("round14_key", Rd_Key, 128'h38383838_39393939_3A3A3A3A_3B3B3B3B);
        idle();
        check("key_hold", Rd_Key, 128'h38383838_39393939_3A3A3A3A_3B3B3B3B);

        // Same-cycle write and read of round 1 returns pre-write data
        cycle(1'b1, 7, 32'hDEAD_BEEF, 1'b1, 1, 1'b0);
        check("rw_old_w7", {96'd0, Rd_Key[31:0]}, 128'h0707_0707);
        cycle(1'b0, 0, 32'd0, 1'b1, 1, 1'b0);
        check("rw_new_w7", {96'd0, Rd_Key[31:0]}, 128'hDEAD_BEEF);

        // Rewrite of a valid word keeps the count
        cycle(1'b1, 5, 32'h55AA_55AA, 1'b0, 0, 1'b0);
        cycle(1'b0, 0, 32'd0, 1'b1, 1, 1'b0);

        // Saturation indices are ignored
        cycle(1'b1, 60, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
        cycle(1'b1, 61, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
        cycle(1'b1, 63, 32'hFFFF_FFFF, 1'b1, 14, 1'b0);

        // Word 0 starts a new key
        cycle(1'b1, 0, 32'hA0A0_A0A0, 1'b0, 0, 1'b0);
        check("newkey_count", {122'd0, Words_Loaded}, 128'd1);
        cycle(1'b0, 0, 32'd0, 1'b1, 1, 1'b0);
        cycle(1'b0, 0, 32'd0, 1'b1, 0, 1'b0);

        // Asynchronous reset mid-load with a request in flight
        for (int i = 1; i < 29; i++) cycle(1'b1, i, 32'h1111_0000 + i, 1'b0, 0, 1'b0);
        cycle(1'b1, 29, 32'h1111_001D, 1'b1, 0, 1'b0);
        Wr_En    = 1'b1;
        Word_Idx = 6'd30;
        Word_In  = 32'h1111_001E;
        Rd_Req   = 1'b1;
        Rd_Round = 4'd0;
        #2;
        Rst = 1'b0;
        #1;
        check("async_rst_valid", {127'd0, Rd_Valid}, 128'd0);
        check("async_rst_err", {127'd0, Rd_Err}, 128'd0);
        check("async_rst_key", Rd_Key, 128'd0);
        check("async_rst_count", {122'd0, Words_Loaded}, 128'd0);
        check("async_rst_done", {127'd0, Keys_Done}, 128'd0);
        @(posedge Clk);
        #1;
        model_reset();
        Wr_En  = 1'b0;
        Rd_Req = 1'b0;
        Rst    = 1'b1;
        idle();
        idle();
        cycle(1'b0, 0, 32'd0, 1'b1, 0, 1'b0);

`ifdef ROUND_KEY_ZEROIZE_EN
        // Zeroization: full load, then Clr
        for (int i = 0; i < 60; i++) cycle(1'b1, i, 32'hC000_0000 + i, 1'b0, 0, 1'b0);
        cycle(1'b0, 0, 32'd0, 1'b1, 3, 1'b1);
        for (int i = 0; i < 15; i++) cycle(1'b1, i, 32'hFFFF_FFFF, 1'b1, i, (i == 4));
        check("wipe_count", {122'd0, Words_Loaded}, 128'd0);
        for (int r = 0; r < 15; r++) cycle(1'b0, 0, 32'd0, 1'b1, r, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
